sqrt_rr_arbiter: RTL
====================

Name: sqrt_rr_arbiter

Overview:
- Shares one iterative square-root core between NREQ independent requesters using round-robin arbitration.
- Accepts one operand at a time, issues it to the core, and collects the result. Returns the result to the requester that was granted, then re-arbitrates.
- Sits between the client blocks and a single sqrt core instance. Only one operation is in flight at any time.

Parameters:
- NREQ, 4, number of requesters (2..16).
- NBITS, 8, operand and result width, matching the core.
- CNTW, 16, width of the served-operation counter.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_a  in  NREQ*NBITS  packed operands; requester i occupies bits [i*NBITS +: NBITS].
- req_ready  out  NREQ  one-hot, one-cycle accept pulse.
- rsp_valid  out  NREQ  one-hot result valid for the owning requester.
- rsp_result  out  NBITS  result; meaningful only while rsp_valid is non-zero.
- rsp_ready  in  NREQ  per-requester result accept.
- core_a  out  NBITS  operand to the core.
- core_ivalid  out  1  operand valid to the core.
- core_iready  in  1  core ready to take an operand.
- core_ovalid  in  1  core result valid.
- core_oready  out  1  result accept to the core.
- core_result  in  NBITS  core result.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  $clog2(NREQ)  index of the current owner; valid while busy.
- served_cnt  out  CNTW  count of completed operations; wraps on overflow.

Behaviour:
- Reset values:
  - State IDLE.
  - req_ready, rsp_valid, core_ivalid, core_oready and busy all 0.
  - core_a, rsp_result, grant_id and served_cnt all 0.
  - Round-robin pointer = 0.
  - Reset asserted in any state aborts the operation in flight without a response. Any core result arriving later is not accepted (core_oready stays 0). The system resets the core together with this block.
- IDLE:
  - If any req_valid is set, select the first set bit at or after the pointer, wrapping modulo NREQ.
  - Next edge: latch the selected operand into core_a, set grant_id, pulse req_ready[g] for exactly one cycle, go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - core_ivalid = 1 and core_a held stable.
  - On a cycle where core_ivalid && core_iready: drop core_ivalid next edge and go to WAIT.
- WAIT:
  - core_oready = 0.
  - On core_ovalid: next edge latch core_result into rsp_result, pulse core_oready for exactly that one cycle, and go to RESP.
- RESP:
  - rsp_valid[g] = 1; rsp_result held stable.
  - On rsp_ready[g]:
    - next edge clear rsp_valid;
    - served_cnt += 1, wrapping from 2^CNTW-1 to 0;
    - pointer = (g+1) mod NREQ;
    - go to IDLE.
  - rsp_ready on any other index is ignored.
- Timing:
  - Minimum latency, req_valid to rsp_valid = 3 cycles + core latency.
  - Minimum gap between successive grants = 1 IDLE cycle.
- Fairness: a requester that keeps req_valid high is served within NREQ operations.
- Requester protocol:
  - A requester must hold req_valid and its operand until it sees req_ready.
  - Deasserting req_valid before a grant is legal; that requester is simply not selected.
- Simultaneous events:
  - req_valid changing in the same cycle as a grant has no effect on the latched operand.
  - rsp_ready arriving on the first RESP cycle completes in that cycle.
  - core_ovalid arriving while in ISSUE is ignored; only WAIT consumes results.
- Pointer wrap: pointer NREQ-1 advances to 0.

Test Plan:
- Bench core model: returns floor(sqrt(a)) 6 cycles after the input handshake; core_iready is always 1.
- Single request: req_valid[2]=1 with a=81 after reset → req_ready[2] pulses once; rsp_valid[2]=1 with rsp_result=9; served_cnt=1; next grant search starts at 3.
- All four requesters valid with a={4,9,16,25} for ids 0..3, rsp_ready always 1 → grant order 0,1,2,3,0; results 2,3,4,5; each req_ready is a one-cycle pulse.
- Pointer at 3, requesters 1 and 3 valid → 3 is granted first, then 1.
- Back-pressure: rsp_ready[0] held low for 10 cycles with a=144 → rsp_valid[0] and rsp_result=12 stay stable; no new grant issued; core_oready pulsed exactly once.
- core_iready held low for 5 cycles in ISSUE → core_ivalid stays 1 and core_a stays stable; WAIT is entered only after the handshake cycle.
- Reset asserted while in WAIT → all outputs return to reset values next edge; a late core_ovalid is not acknowledged; served_cnt=0.

Source files
------------

// File: rtl/sqrt_rr_arbiter.sv
// Round-robin arbiter that shares one iterative square-root core among NREQ requesters.
// One operation is in flight at a time; the owner must take its result before re-arbitration.
module sqrt_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int CNTW  = 16,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*NBITS-1:0] req_a,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [NBITS-1:0]      rsp_result,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [NBITS-1:0]      core_a,
  output logic                  core_ivalid,
  input  logic                  core_iready,
  input  logic                  core_ovalid,
  output logic                  core_oready,
  input  logic [NBITS-1:0]      core_result,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id,
  output logic [CNTW-1:0]       served_cnt
);

  // state | meaning
  // IDLE  | no owner; pick first valid requester at or after the pointer
  // ISSUE | operand presented to the core until core_iready
  // WAIT  | operand taken; waiting for core_ovalid
  // RESP  | result held for the owner until rsp_ready[owner]
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  state_t           state_q;
  logic [NREQ-1:0]  req_ready_q;
  logic [NREQ-1:0]  rsp_valid_q;
  logic [NBITS-1:0] rsp_result_q;
  logic [NBITS-1:0] core_a_q;
  logic             core_ivalid_q;
  logic             core_oready_q;
  logic             busy_q;
  logic [IDW-1:0]   grant_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   ptr_d;
  logic [CNTW-1:0]  served_q;
  logic [CNTW-1:0]  served_d;

  logic [NBITS-1:0] a_arr [NREQ];
  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   sel_id;
  logic             sel_found;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = req_a[i*NBITS +: NBITS];
    end
  end

  // Scan from the farthest offset down so the closest valid requester to the pointer wins.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = IDW'((int'(ptr_q) + i) % NREQ);
      if (req_valid[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  assign ptr_d    = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + IDW'(1);
  assign served_d = served_q + CNTW'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      req_ready_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_result_q  <= '0;
      core_a_q      <= '0;
      core_ivalid_q <= 1'b0;
      core_oready_q <= 1'b0;
      busy_q        <= 1'b0;
      grant_q       <= '0;
      ptr_q         <= '0;
      served_q      <= '0;
    end else begin
      req_ready_q   <= '0;
      core_oready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            grant_q       <= sel_id;
            core_a_q      <= a_arr[sel_id];
            req_ready_q   <= ONE << sel_id;
            core_ivalid_q <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          if (core_iready) begin
            core_ivalid_q <= 1'b0;
            state_q       <= WAIT;
          end
        end
        WAIT: begin
          if (core_ovalid) begin
            rsp_result_q  <= core_result;
            core_oready_q <= 1'b1;
            rsp_valid_q   <= ONE << grant_q;
            state_q       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready[grant_q]) begin
            rsp_valid_q <= '0;
            served_q    <= served_d;
            ptr_q       <= ptr_d;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign core_a      = core_a_q;
  assign core_ivalid = core_ivalid_q;
  assign core_oready = core_oready_q;
  assign busy        = busy_q;
  assign grant_id    = grant_q;
  assign served_cnt  = served_q;

endmodule
